// File: rtl/tpu_scheduler_pkg.sv
// Shared types for the tpu_scheduler command front-end: response status codes
// and scheduler FSM state encodings.
package tpu_scheduler_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 16;

   typedef enum logic [1:0] {
      STAT_OK      = 2'd0,
      STAT_REJECT  = 2'd1,
      STAT_TIMEOUT = 2'd2
   } status_e;

   typedef enum logic [1:0] {
      SCH_IDLE   = 2'd0,
      SCH_LAUNCH = 2'd1,
      SCH_RUN    = 2'd2,
      SCH_RESP   = 2'd3
   } sch_state_e;

endpackage

// File: rtl/tpu_scheduler_cmd_fifo.sv
// Synchronous command queue: registered count, no bypass, head read straight
// from storage so a push is visible at the head on the following cycle.
module cmd_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_c,
   output logic             full_c,
   output logic             empty_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok, pop_ok;

   assign full_c  = (count_q == CNT_W'(DEPTH));
   assign empty_c = (count_q == '0);
   assign push_ok = push_i && !full_c;
   assign pop_ok  = pop_i && !empty_c;
   assign head_c  = mem[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/tpu_scheduler.sv
// Command front-end for the tpu core: queues matmul commands, launches them one
// at a time, and returns a tagged OK/REJECT/TIMEOUT response for each.
module tpu_scheduler
   import tpu_scheduler_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned TAG_WIDTH  = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 65535
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0] cmd_m_i,
   input  logic [ADDR_WIDTH-1:0] cmd_k_i,
   input  logic [ADDR_WIDTH-1:0] cmd_n_i,
   input  logic [ADDR_WIDTH-1:0] cmd_base_addra_i,
   input  logic [ADDR_WIDTH-1:0] cmd_base_addrb_i,
   input  logic [ADDR_WIDTH-1:0] cmd_base_addrp_i,
   input  logic [TAG_WIDTH-1:0]  cmd_tag_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [TAG_WIDTH-1:0]  rsp_tag_o,
   output logic [1:0]            rsp_status_o,
   output logic                  tpu_start_o,
   input  logic                  tpu_valid_i,
   output logic [ADDR_WIDTH-1:0] tpu_m_o,
   output logic [ADDR_WIDTH-1:0] tpu_k_o,
   output logic [ADDR_WIDTH-1:0] tpu_n_o,
   output logic [ADDR_WIDTH-1:0] tpu_base_addra_o,
   output logic [ADDR_WIDTH-1:0] tpu_base_addrb_o,
   output logic [ADDR_WIDTH-1:0] tpu_base_addrp_o,
   output logic                  busy_o,
   output logic                  fault_o
);

   localparam int unsigned DATA_W = 6 * ADDR_WIDTH + TAG_WIDTH;
   localparam int unsigned WD_W   = $clog2(TIMEOUT);

   logic [DATA_W-1:0]     head_c;
   logic                  full_c, empty_c, pop_c;
   logic [ADDR_WIDTH-1:0] h_m, h_k, h_n, h_a, h_b, h_p;
   logic [TAG_WIDTH-1:0]  h_tag;

   sch_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] m_q, k_q, n_q, a_q, b_q, p_q;
   logic [TAG_WIDTH-1:0]  rsp_tag_q;
   status_e               rsp_status_q, rsp_status_c;
   logic                  rsp_load_c, fault_set_c;
   logic                  rsp_valid_q, start_q, busy_q, fault_q;
   logic [WD_W-1:0]       wd_q;

   cmd_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (cmd_valid_i),
      .pop_i   (pop_c),
      .data_i  ({cmd_m_i, cmd_k_i, cmd_n_i, cmd_base_addra_i,
                 cmd_base_addrb_i, cmd_base_addrp_i, cmd_tag_i}),
      .head_c  (head_c),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

   assign {h_m, h_k, h_n, h_a, h_b, h_p, h_tag} = head_c;

   // Next-state and transfer decode.
   always_comb begin
      state_d      = state_q;
      pop_c        = 1'b0;
      rsp_load_c   = 1'b0;
      rsp_status_c = STAT_OK;
      fault_set_c  = 1'b0;
      case (state_q)
         SCH_IDLE: begin
            if (!empty_c && !fault_q) begin
               pop_c = 1'b1;
               if (h_m == '0 || h_k == '0 || h_n == '0) begin
                  state_d      = SCH_RESP;
                  rsp_load_c   = 1'b1;
                  rsp_status_c = STAT_REJECT;
               end else begin
                  state_d = SCH_LAUNCH;
               end
            end
         end
         SCH_LAUNCH: state_d = SCH_RUN;
         SCH_RUN: begin
            // Completion takes priority over a coincident watchdog expiry.
            if (tpu_valid_i) begin
               state_d    = SCH_RESP;
               rsp_load_c = 1'b1;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               state_d      = SCH_RESP;
               rsp_load_c   = 1'b1;
               rsp_status_c = STAT_TIMEOUT;
               fault_set_c  = 1'b1;
            end
         end
         SCH_RESP: begin
            if (rsp_ready_i) state_d = SCH_IDLE;
         end
         default: state_d = SCH_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= SCH_IDLE;
         {m_q, k_q, n_q, a_q, b_q, p_q} <= '0;
         rsp_tag_q    <= '0;
         rsp_status_q <= STAT_OK;
         rsp_valid_q  <= 1'b0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         fault_q      <= 1'b0;
         wd_q         <= '0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= (state_d == SCH_RESP);
         start_q     <= (state_d == SCH_LAUNCH);
         busy_q      <= (state_d != SCH_IDLE);
         fault_q     <= fault_q | fault_set_c;
         if (pop_c) begin
            {m_q, k_q, n_q, a_q, b_q, p_q} <= {h_m, h_k, h_n, h_a, h_b, h_p};
            rsp_tag_q <= h_tag;
         end
         if (rsp_load_c) rsp_status_q <= rsp_status_c;
         if (state_q == SCH_LAUNCH)   wd_q <= '0;
         else if (state_q == SCH_RUN) wd_q <= wd_q + WD_W'(1);
      end
   end

   assign cmd_ready_o      = !full_c;
   assign rsp_valid_o      = rsp_valid_q;
   assign rsp_tag_o        = rsp_tag_q;
   assign rsp_status_o     = rsp_status_q;
   assign tpu_start_o      = start_q;
   assign tpu_m_o          = m_q;
   assign tpu_k_o          = k_q;
   assign tpu_n_o          = n_q;
   assign tpu_base_addra_o = a_q;
   assign tpu_base_addrb_o = b_q;
   assign tpu_base_addrp_o = p_q;
   assign busy_o           = busy_q;
   assign fault_o          = fault_q;

endmodule

// File: tb/tb_tpu_scheduler.sv
// Self-checking bench for tpu_scheduler: scoreboard of expected responses plus
// a behavioural core model that answers start pulses after a set delay.
module tb_tpu_scheduler;

   localparam int unsigned AW = 16;
   localparam int unsigned TW = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_ready_o;
   logic [AW-1:0] cmd_m_i = '0, cmd_k_i = '0, cmd_n_i = '0;
   logic [AW-1:0] cmd_base_addra_i = '0, cmd_base_addrb_i = '0, cmd_base_addrp_i = '0;
   logic [TW-1:0] cmd_tag_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b1;
   logic [TW-1:0] rsp_tag_o;
   logic [1:0]    rsp_status_o;
   logic          tpu_start_o;
   logic          tpu_valid_i = 1'b0;
   logic [AW-1:0] tpu_m_o, tpu_k_o, tpu_n_o;
   logic [AW-1:0] tpu_base_addra_o, tpu_base_addrb_o, tpu_base_addrp_o;
   logic          busy_o, fault_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_starts = 0, n_rsp = 0, start_cyc = 0, last_rsp_cyc = 0;
   int cd = 0, core_delay = 10, t_push = 0;
   bit core_en = 1'b1, spur = 1'b0, prev_start = 1'b0;
   logic [TW+1:0] exp_q[$];
   logic [TW+1:0] exp_v;

   tpu_scheduler #(
      .ADDR_WIDTH (AW),
      .TAG_WIDTH  (TW),
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TO)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .cmd_valid_i      (cmd_valid_i),
      .cmd_ready_o      (cmd_ready_o),
      .cmd_m_i          (cmd_m_i),
      .cmd_k_i          (cmd_k_i),
      .cmd_n_i          (cmd_n_i),
      .cmd_base_addra_i (cmd_base_addra_i),
      .cmd_base_addrb_i (cmd_base_addrb_i),
      .cmd_base_addrp_i (cmd_base_addrp_i),
      .cmd_tag_i        (cmd_tag_i),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_ready_i      (rsp_ready_i),
      .rsp_tag_o        (rsp_tag_o),
      .rsp_status_o     (rsp_status_o),
      .tpu_start_o      (tpu_start_o),
      .tpu_valid_i      (tpu_valid_i),
      .tpu_m_o          (tpu_m_o),
      .tpu_k_o          (tpu_k_o),
      .tpu_n_o          (tpu_n_o),
      .tpu_base_addra_o (tpu_base_addra_o),
      .tpu_base_addrb_o (tpu_base_addrb_o),
      .tpu_base_addrp_o (tpu_base_addrp_o),
      .busy_o           (busy_o),
      .fault_o          (fault_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Core model: one-cycle completion core_delay cycles after each start.
   always @(negedge clk) begin
      if (!rst_ni) begin
         cd = 0;
         tpu_valid_i = 1'b0;
         prev_start = 1'b0;
      end else begin
         tpu_valid_i = spur;
         if (cd > 0) begin
            cd--;
            if (cd == 0) tpu_valid_i = 1'b1;
         end
         if (tpu_start_o) begin
            checks++;
            if (prev_start) begin
               errors++;
               $display("FAIL start_pulse: start high two cycles in a row at cycle %0d", cyc);
            end
            if (n_rsp > 0) begin
               checks++;
               if (cyc < last_rsp_cyc + 2) begin
                  errors++;
                  $display("FAIL start_spacing: start at cycle %0d, last response at %0d, need >= %0d", cyc, last_rsp_cyc, last_rsp_cyc + 2);
               end
            end
            n_starts++;
            start_cyc = cyc;
            cd = core_en ? core_delay : 0;
         end
         prev_start = tpu_start_o;
      end
   end

   // Response monitor: every accepted response must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_ni && rsp_valid_o && rsp_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got tag %0d status %0d, none expected", rsp_tag_o, rsp_status_o);
         end else begin
            exp_v = exp_q.pop_front();
            if ({rsp_tag_o, rsp_status_o} !== exp_v) begin
               errors++;
               $display("FAIL rsp_fields: got tag %0d status %0d, expected tag %0d status %0d", rsp_tag_o, rsp_status_o, exp_v[TW+1:2], exp_v[1:0]);
            end
         end
         n_rsp++;
         last_rsp_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input int m, input int k, input int n, input int tag,
                           input logic [1:0] st, input bit expect_rsp);
      int n_wait = 0;
      cmd_valid_i = 1'b1;
      cmd_m_i = AW'(m);
      cmd_k_i = AW'(k);
      cmd_n_i = AW'(n);
      cmd_tag_i = TW'(tag);
      cmd_base_addra_i = AW'(16'h1000 + tag);
      cmd_base_addrb_i = AW'(16'h2000 + tag);
      cmd_base_addrp_i = AW'(16'h3000 + tag);
      @(negedge clk);
      while (!cmd_ready_o && n_wait < 200) begin
         @(negedge clk);
         n_wait++;
      end
      if (!cmd_ready_o) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: tag %0d never accepted, ready %0b, required 1", tag, cmd_ready_o);
      end else begin
         t_push = cyc;
         if (expect_rsp) exp_q.push_back({TW'(tag), st});
      end
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while (!(exp_q.size() == 0 && !busy_o && !rsp_valid_o) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_drain: %0d responses outstanding, busy %0b, required 0 and 0", name, exp_q.size(), busy_o);
      end
      tick();
   endtask

   task automatic apply_reset();
      rst_ni = 1'b0;
      exp_q.delete();
      spur = 1'b0;
      repeat (2) tick();
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({cmd_ready_o, rsp_valid_o, tpu_start_o, busy_o, fault_o} !== 5'b10000) begin
         errors++;
         $display("FAIL %s_ctrl: ready/rsp_valid/start/busy/fault = %b, required 10000", name, {cmd_ready_o, rsp_valid_o, tpu_start_o, busy_o, fault_o});
      end
      checks++;
      if ({rsp_tag_o, rsp_status_o} !== '0) begin
         errors++;
         $display("FAIL %s_rsp: tag %0d status %0d, required 0 0", name, rsp_tag_o, rsp_status_o);
      end
      checks++;
      if ({tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_addra_o, tpu_base_addrb_o, tpu_base_addrp_o} !== '0) begin
         errors++;
         $display("FAIL %s_cfg: m %0d k %0d n %0d a %h b %h p %h, required all 0", name, tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_addra_o, tpu_base_addrb_o, tpu_base_addrp_o);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) tick();
      check_reset_outputs("reset_held");
      rst_ni = 1'b1;
      tick();
      check_reset_outputs("reset_released");
   endtask

   task automatic test_single();
      int s0 = n_starts;
      core_en = 1'b1;
      core_delay = 10;
      push_cmd(8, 8, 8, 3, 2'd0, 1'b1);
      repeat (3) tick();
      checks++;
      if (start_cyc !== t_push + 2 || n_starts !== s0 + 1) begin
         errors++;
         $display("FAIL single_start: start at cycle %0d (count %0d), required %0d (count %0d)", start_cyc, n_starts - s0, t_push + 2, 1);
      end
      checks++;
      if ({tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_addrp_o} !== {AW'(8), AW'(8), AW'(8), AW'(16'h3003)}) begin
         errors++;
         $display("FAIL single_cfg: m %0d k %0d n %0d p %h, required 8 8 8 3003", tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_addrp_o);
      end
      wait_idle(100, "single");
      checks++;
      if (last_rsp_cyc !== start_cyc + 11) begin
         errors++;
         $display("FAIL single_latency: response at cycle %0d, required %0d", last_rsp_cyc, start_cyc + 11);
      end
      checks++;
      if (n_starts !== s0 + 1) begin
         errors++;
         $display("FAIL single_count: %0d start pulses, required 1", n_starts - s0);
      end
   endtask

   task automatic test_back_to_back();
      int s0 = n_starts;
      int r0 = n_rsp;
      int n = 0;
      core_delay = 16;
      for (int i = 0; i < 5; i++) push_cmd(i + 1, 2, 3, i, 2'd0, 1'b1);
      @(negedge clk);
      checks++;
      if (cmd_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_full: ready %0b with queue full, required 0", cmd_ready_o);
      end
      while (!cmd_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cmd_ready_o !== 1'b1 || n_rsp !== r0 + 1) begin
         errors++;
         $display("FAIL b2b_ready_rise: ready %0b after %0d responses, required 1 after 1", cmd_ready_o, n_rsp - r0);
      end
      tick();
      wait_idle(300, "b2b");
      checks++;
      if (n_starts !== s0 + 5) begin
         errors++;
         $display("FAIL b2b_starts: %0d start pulses, required 5", n_starts - s0);
      end
   endtask

   task automatic test_reject();
      int s0 = n_starts;
      core_delay = 6;
      push_cmd(8, 8, 8, 5, 2'd0, 1'b1);
      push_cmd(8, 0, 8, 6, 2'd1, 1'b1);
      push_cmd(4, 4, 4, 7, 2'd0, 1'b1);
      push_cmd(0, 4, 4, 8, 2'd1, 1'b1);
      wait_idle(200, "reject");
      checks++;
      if (n_starts !== s0 + 2) begin
         errors++;
         $display("FAIL reject_starts: %0d start pulses, required 2", n_starts - s0);
      end
   endtask

   task automatic test_rsp_stall();
      int s0 = n_starts;
      int n = 0;
      core_delay = 10;
      rsp_ready_i = 1'b0;
      push_cmd(9, 9, 9, 9, 2'd0, 1'b1);
      push_cmd(2, 2, 2, 10, 2'd0, 1'b1);
      @(negedge clk);
      while (!rsp_valid_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      tick();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid_o, rsp_tag_o, rsp_status_o, tpu_start_o} !== {1'b1, TW'(9), 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d valid %0b tag %0d status %0d start %0b, required 1 9 0 0", i, rsp_valid_o, rsp_tag_o, rsp_status_o, tpu_start_o);
         end
         tick();
         spur = (i == 3);
      end
      spur = 1'b0;
      rsp_ready_i = 1'b1;
      wait_idle(100, "stall");
      checks++;
      if (n_starts !== s0 + 2) begin
         errors++;
         $display("FAIL stall_starts: %0d start pulses, required 2", n_starts - s0);
      end
   endtask

   task automatic test_timeout();
      int s0 = n_starts;
      core_en = 1'b0;
      push_cmd(5, 5, 5, 11, 2'd2, 1'b1);
      push_cmd(5, 5, 5, 12, 2'd0, 1'b0);
      wait_idle(100, "timeout");
      checks++;
      if (last_rsp_cyc !== start_cyc + 1 + TO) begin
         errors++;
         $display("FAIL timeout_latency: response at cycle %0d, required %0d", last_rsp_cyc, start_cyc + 1 + TO);
      end
      repeat (30) tick();
      checks++;
      if ({fault_o, busy_o} !== 2'b10 || n_starts !== s0 + 1) begin
         errors++;
         $display("FAIL timeout_fault: fault %0b busy %0b starts %0d, required 1 0 1", fault_o, busy_o, n_starts - s0);
      end
      for (int i = 0; i < 3; i++) push_cmd(1, 1, 1, 13 + i, 2'd0, 1'b0);
      @(negedge clk);
      checks++;
      if (cmd_ready_o !== 1'b0 || n_starts !== s0 + 1) begin
         errors++;
         $display("FAIL timeout_fill: ready %0b starts %0d, required 0 1", cmd_ready_o, n_starts - s0);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int s0, r0;
      apply_reset();
      core_en = 1'b0;
      push_cmd(3, 3, 3, 1, 2'd0, 1'b0);
      push_cmd(3, 3, 3, 2, 2'd0, 1'b0);
      push_cmd(3, 3, 3, 3, 2'd0, 1'b0);
      repeat (4) tick();
      checks++;
      if (busy_o !== 1'b1 || fault_o !== 1'b0) begin
         errors++;
         $display("FAIL midrun_busy: busy %0b fault %0b, required 1 0", busy_o, fault_o);
      end
      s0 = n_starts;
      r0 = n_rsp;
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      repeat (2) tick();
      rst_ni = 1'b1;
      repeat (40) tick();
      checks++;
      if (n_rsp !== r0 || n_starts !== s0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL midrun_quiet: responses %0d starts %0d busy %0b ready %0b, required 0 0 0 1", n_rsp - r0, n_starts - s0, busy_o, cmd_ready_o);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reject();
      test_rsp_stall();
      test_timeout();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, errors %0d", errors);
      $fatal(1);
   end

endmodule
